// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: register map, CTRL bit positions and shared helpers for wb_timer
package wb_timer_pkg;
  localparam int PRESCALE_W = 16;
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_PRESCALE = 8'h04;
  localparam logic [7:0] REG_COMPARE = 8'h08;
  localparam logic [7:0] REG_COUNT = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wdat,
                                              input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = sel[i] ? wdat[8*i+:8] : cur[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides clk by prescale+1 while enabled, restartable via clear
module wb_timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] pre_cnt;
  assign tick = en & (pre_cnt == prescale);
  always_ff @(posedge clk) begin
    if (!resetn || clear || !en || tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end
endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone-slave prescaled 32-bit timer with compare match and level interrupt
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0300_1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_irq
);
  logic en, auto_reload, irq_en, match_flag;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0] compare, count, rdata;
  logic [7:0] off;
  logic req, wr, wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_sts, tick, is_match, unused_addr;
  assign off = {i_wb_addr[7:2], 2'b00};
  assign unused_addr = ^i_wb_addr[1:0];
  assign req = i_wb_cyc & i_wb_stb & (i_wb_addr[31:8] == BASE_ADDRESS[31:8]) & !o_wb_ack;
  assign wr = req & i_wb_we;
  assign wr_ctrl = wr & (off == REG_CTRL);
  assign wr_pre = wr & (off == REG_PRESCALE);
  assign wr_cmp = wr & (off == REG_COMPARE);
  assign wr_cnt = wr & (off == REG_COUNT);
  assign wr_sts = wr & (off == REG_STATUS);
  assign is_match = count == compare;
  assign o_irq = match_flag & irq_en;
  always_comb begin
    rdata = off == REG_CTRL     ? {29'd0, irq_en, auto_reload, en} :
            off == REG_PRESCALE ? {16'd0, prescale} :
            off == REG_COMPARE  ? compare :
            off == REG_COUNT    ? count :
            off == REG_STATUS   ? {31'd0, match_flag} : '0;
  end
  // Any register write that moves the count or the period restarts the prescaler phase
  wb_timer_prescaler u_pre (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .clear    (wr_pre | wr_cnt),
    .prescale (prescale),
    .tick     (tick)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_wb_ack <= 1'b0;
      o_wb_data <= '0;
      en <= 1'b0;
      auto_reload <= 1'b0;
      irq_en <= 1'b0;
      match_flag <= 1'b0;
      prescale <= '0;
      compare <= '0;
      count <= '0;
    end else begin
      o_wb_ack <= req;
      o_wb_data <= (req & !i_wb_we) ? rdata : '0;
      if (wr_ctrl & i_wb_sel[0]) begin
        en <= i_wb_data[CTRL_EN];
        auto_reload <= i_wb_data[CTRL_AUTO_RELOAD];
        irq_en <= i_wb_data[CTRL_IRQ_EN];
      end else if (tick & is_match & !auto_reload) en <= 1'b0;
      if (wr_pre) prescale <= {i_wb_sel[1] ? i_wb_data[15:8] : prescale[15:8],
                               i_wb_sel[0] ? i_wb_data[7:0] : prescale[7:0]};
      if (wr_cmp) compare <= merge_bytes(compare, i_wb_data, i_wb_sel);
      if (wr_cnt) count <= merge_bytes(count, i_wb_data, i_wb_sel);
      else if (tick) count <= is_match ? (auto_reload ? '0 : count) : count + 32'd1;
      if (tick & is_match) match_flag <= 1'b1;
      else if (wr_sts & i_wb_sel[0] & i_wb_data[0]) match_flag <= 1'b0;
    end
  end
endmodule
